// File: rtl/pipeline_ctrl_pkg.sv
// Shared types for the pipeline hazard/sequencing controller.
// Stages consume one stage_ctrl_t each: hold the stage register or load a bubble.
package pipeline_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_REQ  = 2'd1,
    MEM_RESP = 2'd2,
    MD_BUSY  = 2'd3
  } ctrl_state_t;

  typedef struct packed {
    logic stall;
    logic flush;
  } stage_ctrl_t;

  localparam stage_ctrl_t STAGE_IDLE = '{stall: 1'b0, flush: 1'b0};

  function automatic logic is_mem_wait(input ctrl_state_t s);
    return (s == MEM_REQ) || (s == MEM_RESP);
  endfunction

endpackage

// File: rtl/pipeline_ctrl_wait_cnt.sv
// Saturating up-counter with synchronous clear.
// Serves both as the memory-wait timeout counter and the stall performance counter.
module pipeline_ctrl_wait_cnt #(
  parameter int unsigned W   = 8,
  parameter logic [W-1:0] MAX = '1
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         i_clr,
  input  logic         i_inc,
  output logic [W-1:0] o_cnt
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_inc && (r_cnt != MAX)) begin
      r_cnt <= r_cnt + W'(1);
    end
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/pipeline_ctrl.sv
// Central hazard/sequencing controller for the 5-stage RV32 pipeline: merges memory,
// MUL/DIV, branch and load-use events into per-stage stall/flush plus a fetch redirect.
module pipeline_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 64,
  parameter int unsigned PERF_W      = 32
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              ld_use_hazard_i,
  input  logic              branch_taken_i,
  input  logic              dmem_req_i,
  input  logic              dmem_gnt_i,
  input  logic              dmem_rvalid_i,
  input  logic              md_start_i,
  input  logic              md_done_i,
  output logic              stall_if_o,
  output logic              stall_id_o,
  output logic              stall_ex_o,
  output logic              stall_mem_o,
  output logic              flush_id_o,
  output logic              flush_ex_o,
  output logic              flush_mem_o,
  output logic              flush_wb_o,
  output logic              redirect_o,
  output logic              unlock_o,
  output logic              mem_timeout_o,
  output logic [PERF_W-1:0] stall_cycles_o
);

  localparam int unsigned TO_W = $clog2(MEM_TIMEOUT + 1);

  ctrl_state_t r_state;
  ctrl_state_t w_state_next;
  logic        w_mem_frz;
  logic        w_md_frz;
  logic        w_frozen;
  logic        w_branch;
  logic        w_ld_use;
  logic        w_stall_if;
  logic        w_flush_wb;
  stage_ctrl_t w_id_ctrl;
  stage_ctrl_t w_ex_ctrl;
  stage_ctrl_t w_mem_ctrl;
  logic        r_unlock;
  logic        r_mem_timeout;
  logic        w_mem_wait;
  logic        w_to_hit;
  logic [TO_W-1:0]   w_to_cnt;
  logic [PERF_W-1:0] w_perf_cnt;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= RUN;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Freeze is raised in the entry cycle and held through the exit cycle.
  always_comb begin
    w_state_next = r_state;
    w_mem_frz    = 1'b0;
    w_md_frz     = 1'b0;
    unique case (r_state)
      RUN: begin
        if (dmem_req_i && !dmem_gnt_i) begin
          w_mem_frz    = 1'b1;
          w_state_next = MEM_REQ;
        end else if (dmem_req_i && !dmem_rvalid_i) begin
          w_mem_frz    = 1'b1;
          w_state_next = MEM_RESP;
        end else if (md_start_i && !md_done_i) begin
          w_md_frz     = 1'b1;
          w_state_next = MD_BUSY;
        end
      end
      MEM_REQ: begin
        w_mem_frz = 1'b1;
        if (dmem_gnt_i) begin
          w_state_next = dmem_rvalid_i ? RUN : MEM_RESP;
        end
      end
      MEM_RESP: begin
        w_mem_frz = 1'b1;
        if (dmem_rvalid_i) begin
          w_state_next = RUN;
        end
      end
      MD_BUSY: begin
        w_md_frz = 1'b1;
        if (md_done_i) begin
          w_state_next = RUN;
        end
      end
      default: begin
        w_state_next = RUN;
      end
    endcase
  end

  // Branch beats load-use (the dependent instr is wrong-path); the cycle right after a
  // load-use stall never stalls again for the same hazard.
  always_comb begin
    w_frozen   = w_mem_frz | w_md_frz;
    w_branch   = !w_frozen && branch_taken_i;
    w_ld_use   = !w_frozen && !branch_taken_i && ld_use_hazard_i && !r_unlock;
    w_stall_if = w_frozen | w_ld_use;
    w_flush_wb = w_mem_frz;
    w_id_ctrl  = STAGE_IDLE;
    w_ex_ctrl  = STAGE_IDLE;
    w_mem_ctrl = STAGE_IDLE;
    w_id_ctrl.stall  = w_frozen | w_ld_use;
    w_id_ctrl.flush  = w_branch;
    w_ex_ctrl.stall  = w_frozen;
    w_ex_ctrl.flush  = w_branch | w_ld_use;
    w_mem_ctrl.stall = w_mem_frz;
    w_mem_ctrl.flush = w_md_frz;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_unlock      <= 1'b0;
      r_mem_timeout <= 1'b0;
    end else begin
      r_unlock      <= w_ld_use;
      r_mem_timeout <= r_mem_timeout | w_to_hit;
    end
  end

  assign w_mem_wait = is_mem_wait(r_state);
  assign w_to_hit   = w_mem_wait && (w_to_cnt == TO_W'(MEM_TIMEOUT - 1));

  pipeline_ctrl_wait_cnt #(
    .W   (TO_W),
    .MAX (TO_W'(MEM_TIMEOUT))
  ) u_timeout_cnt (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .i_clr  (!w_mem_wait),
    .i_inc  (w_mem_wait),
    .o_cnt  (w_to_cnt)
  );

  pipeline_ctrl_wait_cnt #(
    .W (PERF_W)
  ) u_perf_cnt (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .i_clr  (1'b0),
    .i_inc  (w_stall_if),
    .o_cnt  (w_perf_cnt)
  );

  assign stall_if_o     = w_stall_if;
  assign stall_id_o     = w_id_ctrl.stall;
  assign stall_ex_o     = w_ex_ctrl.stall;
  assign stall_mem_o    = w_mem_ctrl.stall;
  assign flush_id_o     = w_id_ctrl.flush;
  assign flush_ex_o     = w_ex_ctrl.flush;
  assign flush_mem_o    = w_mem_ctrl.flush;
  assign flush_wb_o     = w_flush_wb;
  assign redirect_o     = w_branch;
  assign unlock_o       = r_unlock;
  assign mem_timeout_o  = r_mem_timeout;
  assign stall_cycles_o = w_perf_cnt;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed self-checking bench for pipeline_ctrl (MEM_TIMEOUT=4).
module tb_pipeline_ctrl;
  import pipeline_ctrl_pkg::*;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        ld_use_hazard_i, branch_taken_i;
  logic        dmem_req_i, dmem_gnt_i, dmem_rvalid_i;
  logic        md_start_i, md_done_i;
  logic        stall_if_o, stall_id_o, stall_ex_o, stall_mem_o;
  logic        flush_id_o, flush_ex_o, flush_mem_o, flush_wb_o;
  logic        redirect_o, unlock_o, mem_timeout_o;
  logic [31:0] stall_cycles_o;

  int checks   = 0;
  int failures = 0;

  pipeline_ctrl #(.MEM_TIMEOUT(4), .PERF_W(32)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .ld_use_hazard_i(ld_use_hazard_i), .branch_taken_i(branch_taken_i),
    .dmem_req_i(dmem_req_i), .dmem_gnt_i(dmem_gnt_i), .dmem_rvalid_i(dmem_rvalid_i),
    .md_start_i(md_start_i), .md_done_i(md_done_i),
    .stall_if_o(stall_if_o), .stall_id_o(stall_id_o), .stall_ex_o(stall_ex_o),
    .stall_mem_o(stall_mem_o),
    .flush_id_o(flush_id_o), .flush_ex_o(flush_ex_o), .flush_mem_o(flush_mem_o),
    .flush_wb_o(flush_wb_o),
    .redirect_o(redirect_o), .unlock_o(unlock_o), .mem_timeout_o(mem_timeout_o),
    .stall_cycles_o(stall_cycles_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // es = {if,id,ex,mem} stalls, ef = {id,ex,mem,wb} flushes, er = redirect
  task automatic chk_ctrl(input string tag, input logic [3:0] es, input logic [3:0] ef,
                          input logic er);
    chk({tag, ".ctrl"},
        32'({stall_if_o, stall_id_o, stall_ex_o, stall_mem_o,
             flush_id_o, flush_ex_o, flush_mem_o, flush_wb_o, redirect_o}),
        32'({es, ef, er}));
  endtask

  task automatic chk_regs(input string tag, input logic eu, input logic et,
                          input logic [31:0] ec);
    chk({tag, ".unlock"}, 32'(unlock_o), 32'(eu));
    chk({tag, ".timeout"}, 32'(mem_timeout_o), 32'(et));
    chk({tag, ".stalls"}, stall_cycles_o, ec);
  endtask

  task automatic chk_state(input string tag, input ctrl_state_t es);
    chk({tag, ".state"}, 32'(dut.r_state), 32'(es));
  endtask

  // Drive one cycle's inputs just after the falling edge; checks follow 1 time unit later.
  task automatic step(input logic lu, input logic br, input logic req, input logic gnt,
                      input logic rv, input logic mds, input logic mdd);
    @(negedge clk_i);
    ld_use_hazard_i = lu;  branch_taken_i = br;
    dmem_req_i = req;      dmem_gnt_i = gnt;    dmem_rvalid_i = rv;
    md_start_i = mds;      md_done_i = mdd;
    #1;
  endtask

  initial begin
    rst_ni = 1'b0;
    ld_use_hazard_i = 1'b0; branch_taken_i = 1'b0;
    dmem_req_i = 1'b0; dmem_gnt_i = 1'b0; dmem_rvalid_i = 1'b0;
    md_start_i = 1'b0; md_done_i = 1'b0;
    #1;
    chk_ctrl("reset", 4'b0000, 4'b0000, 1'b0);
    chk_regs("reset", 1'b0, 1'b0, 32'd0);
    chk_state("reset", RUN);
    @(negedge clk_i);
    rst_ni = 1'b1;

    // Load-use: one stall cycle, unlock pulse next cycle
    step(1, 0, 0, 0, 0, 0, 0);
    chk_ctrl("lu_c1", 4'b1100, 4'b0100, 1'b0);
    chk_regs("lu_c1", 1'b0, 1'b0, 32'd0);
    step(0, 0, 0, 0, 0, 0, 0);
    chk_ctrl("lu_c2", 4'b0000, 4'b0000, 1'b0);
    chk_regs("lu_c2", 1'b1, 1'b0, 32'd1);
    step(0, 0, 0, 0, 0, 0, 0);
    chk_regs("lu_c3", 1'b0, 1'b0, 32'd1);

    // Branch suppresses a simultaneous load-use
    step(1, 1, 0, 0, 0, 0, 0);
    chk_ctrl("br_lu", 4'b0000, 4'b1100, 1'b1);
    step(0, 0, 0, 0, 0, 0, 0);
    chk_ctrl("br_after", 4'b0000, 4'b0000, 1'b0);
    chk_regs("br_after", 1'b0, 1'b0, 32'd1);

    // MUL/DIV freeze with branch held; redirect waits for the first unfrozen cycle
    for (int i = 1; i <= 5; i++) begin
      step(0, 1, 0, 0, 0, 1, (i == 5));
      chk_ctrl($sformatf("md_c%0d", i), 4'b1110, 4'b0010, 1'b0);
      chk_regs($sformatf("md_c%0d", i), 1'b0, 1'b0, 32'(i));
      chk_state($sformatf("md_c%0d", i), (i == 1) ? RUN : MD_BUSY);
    end
    step(0, 1, 0, 0, 0, 0, 0);
    chk_ctrl("md_c6", 4'b0000, 4'b1100, 1'b1);
    chk_regs("md_c6", 1'b0, 1'b0, 32'd6);
    chk_state("md_c6", RUN);
    step(0, 0, 0, 0, 0, 0, 0);
    chk_ctrl("md_c7", 4'b0000, 4'b0000, 1'b0);

    // Memory handshake: 3 cycles no grant, 2 waiting for response, then response
    step(0, 0, 1, 0, 0, 0, 0);
    chk_ctrl("mem_c1", 4'b1111, 4'b0001, 1'b0);
    chk_state("mem_c1", RUN);
    step(0, 0, 1, 0, 0, 0, 0);
    chk_state("mem_c2", MEM_REQ);
    chk_regs("mem_c2", 1'b0, 1'b0, 32'd7);
    step(0, 0, 1, 0, 0, 0, 0);
    chk_ctrl("mem_c3", 4'b1111, 4'b0001, 1'b0);
    step(0, 0, 1, 1, 0, 0, 0);
    chk_ctrl("mem_c4", 4'b1111, 4'b0001, 1'b0);
    chk_state("mem_c4", MEM_REQ);
    step(0, 0, 1, 1, 0, 0, 0);
    chk_state("mem_c5", MEM_RESP);
    chk_regs("mem_c5", 1'b0, 1'b0, 32'd10);
    step(0, 0, 1, 1, 1, 0, 0);
    chk_ctrl("mem_c6", 4'b1111, 4'b0001, 1'b0);
    chk_state("mem_c6", MEM_RESP);
    chk_regs("mem_c6", 1'b0, 1'b1, 32'd11);
    step(0, 0, 0, 0, 0, 0, 0);
    chk_ctrl("mem_c7", 4'b0000, 4'b0000, 1'b0);
    chk_state("mem_c7", RUN);
    chk_regs("mem_c7", 1'b0, 1'b1, 32'd12);

    // Asynchronous reset in the middle of an MD freeze
    step(0, 0, 0, 0, 0, 1, 0);
    step(0, 1, 0, 0, 0, 1, 0);
    chk_state("rst_pre", MD_BUSY);
    chk_ctrl("rst_pre", 4'b1110, 4'b0010, 1'b0);
    #2;
    rst_ni = 1'b0;
    branch_taken_i = 1'b0; md_start_i = 1'b0;
    #1;
    chk_ctrl("rst_async", 4'b0000, 4'b0000, 1'b0);
    chk_regs("rst_async", 1'b0, 1'b0, 32'd0);
    chk_state("rst_async", RUN);
    @(negedge clk_i);
    rst_ni = 1'b1;
    step(0, 0, 0, 0, 0, 0, 0);
    chk_ctrl("rst_rel", 4'b0000, 4'b0000, 1'b0);
    chk_state("rst_rel", RUN);

    // Timeout: grant withheld, flag rises after 4 wait cycles and stays set
    for (int i = 1; i <= 7; i++) begin
      step(0, 0, 1, 0, 0, 0, 0);
      chk_ctrl($sformatf("to_c%0d", i), 4'b1111, 4'b0001, 1'b0);
      chk_regs($sformatf("to_c%0d", i), 1'b0, (i >= 6), 32'(i - 1));
    end
    step(0, 0, 1, 1, 1, 0, 0);
    chk_ctrl("to_c8", 4'b1111, 4'b0001, 1'b0);
    chk_state("to_c8", MEM_REQ);
    step(0, 0, 0, 0, 0, 0, 0);
    chk_ctrl("to_c9", 4'b0000, 4'b0000, 1'b0);
    chk_state("to_c9", RUN);
    chk_regs("to_c9", 1'b0, 1'b1, 32'd8);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pipeline_ctrl.md
Name: pipeline_ctrl

Overview:
- Central hazard and sequencing controller for the 5-stage RV32 pipeline (IF/ID/EX/MEM/WB).
- Merges four event sources into per-stage stall and flush (bubble) enables plus a fetch redirect:
  - load-use hazard from the ID-stage stall detector
  - branch/jump redirect resolved in EX
  - data-memory request/grant/response handshake in MEM
  - multi-cycle MUL/DIV unit in EX
- Owns the only pipeline-freeze FSM, a memory-wait timeout, and a stall performance counter.

Parameters:
- MEM_TIMEOUT, 64, max cycles in a memory-wait state before mem_timeout_o fires (≥2).
- PERF_W, 32, width of stall_cycles_o.

Ports:
- clk_i  in  1  core clock
- rst_ni  in  1  asynchronous active-low reset
- ld_use_hazard_i  in  1  ID instr needs rd of load now in EX
- branch_taken_i  in  1  EX instr redirects PC (taken branch, JAL, JALR)
- dmem_req_i  in  1  MEM stage issues load/store this cycle
- dmem_gnt_i  in  1  memory accepted request
- dmem_rvalid_i  in  1  memory response/ack valid
- md_start_i  in  1  EX holds MUL/DIV needing multiple cycles
- md_done_i  in  1  MUL/DIV result valid
- stall_if_o, stall_id_o, stall_ex_o, stall_mem_o  out  1 each  hold stage register
- flush_id_o, flush_ex_o, flush_mem_o, flush_wb_o  out  1 each  load NOP (riscv::I_NOP) into stage register
- redirect_o  out  1  IF takes branch target this cycle
- unlock_o  out  1  one-cycle pulse, cycle after a load-use stall
- mem_timeout_o  out  1  sticky timeout flag
- stall_cycles_o  out  PERF_W  saturating count of cycles with stall_if_o=1

Behaviour:
- Reset: state RUN; unlock_o=0, mem_timeout_o=0, stall_cycles_o=0, timeout counter=0.
  - All stall/flush/redirect outputs are combinational. In RUN with all inputs 0 they are 0.
- FSM states: RUN, MEM_REQ, MEM_RESP, MD_BUSY.
- Freeze outputs, combinational from state plus the entry/exit condition in the same cycle:
  - Mem freeze: stall IF, ID, EX, MEM; flush_wb=1.
  - MD freeze: stall IF, ID, EX; flush_mem=1.
- RUN transitions:
  - dmem_req & !gnt → mem freeze now; next state MEM_REQ.
  - dmem_req & gnt & !rvalid → mem freeze now; next state MEM_RESP.
  - dmem_req & gnt & rvalid → no stall.
  - Otherwise md_start & !md_done → MD freeze now; next state MD_BUSY.
  - md_start & md_done in the same cycle → no stall.
- MEM_REQ: freeze; gnt&rvalid → RUN (freeze still on this cycle); gnt&!rvalid → MEM_RESP.
- MEM_RESP: freeze; rvalid → RUN (freeze still on this cycle).
- MD_BUSY: MD freeze; md_done → RUN (freeze still on this cycle).
  - Any dmem event while in MD_BUSY is ignored: MEM holds a bubble.
- Priority (highest first): mem freeze > MD freeze > branch > load-use.
- While frozen, branch_taken_i and ld_use_hazard_i are ignored. EX/ID are held, so these inputs persist and act on the first unfrozen cycle.
- Branch, unfrozen: redirect=1, flush_id=1, flush_ex=1; no stall. Suppresses a simultaneous load-use (wrong-path instr).
- Load-use, unfrozen, no branch: stall_if=1, stall_id=1, flush_ex=1. Exactly one cycle per assertion. unlock_o=1 on the next cycle.
- Timeout counter:
  - Increments each cycle in MEM_REQ/MEM_RESP; clears in RUN.
  - Reaching MEM_TIMEOUT sets mem_timeout_o until reset; the FSM keeps waiting.
- stall_cycles_o: +1 each cycle stall_if_o=1; saturates at all-ones.
- Async reset mid-freeze: immediate return to reset values; no pending redirect is retained.

Decomposition:
- core package gets:
  - typedef ctrl_state_t {RUN, MEM_REQ, MEM_RESP, MD_BUSY}
  - packed struct stage_ctrl_t {stall, flush}, so stages consume one field each
- One sub-module, pipeline_ctrl_wait_cnt: timeout counter plus saturating perf counter, reused for both.

Test Plan:
- Reset, then ld_use_hazard_i=1 for 1 cycle → that cycle stall_if/id=1, flush_ex=1; next cycle unlock_o=1; stall_cycles_o=1.
- branch_taken_i=1 and ld_use_hazard_i=1 same cycle → redirect=1, flush_id=flush_ex=1, stall_if=0, unlock_o stays 0.
- dmem_req=1, gnt=0 for 3 cycles, then gnt=1, rvalid=0 for 2 cycles, then rvalid=1 → mem freeze 6 cycles; states RUN→MEM_REQ→MEM_RESP→RUN; stall_cycles_o=6.
- md_start=1, md_done on 5th cycle, branch_taken_i held high throughout → stall_if 5 cycles, flush_mem=1 each; redirect=1 on cycle 6 only.
- MEM_TIMEOUT=4, gnt never asserted → mem_timeout_o rises 4 cycles after entry and stays 1; grant then releases the freeze, flag remains.
- rst_ni low during MD_BUSY → all outputs 0 asynchronously; state RUN after release.
